// File: rtl/down_counter_parallel_load.sv
// N-bit synchronous down counter with parallel load, auto-reload register,
// combinational borrow-out Z for cascading and a registered terminal-count pulse.
module down_counter_parallel_load #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         En,
    input  logic         load,
    input  logic [N-1:0] C,
    input  logic         reload_en,
    output logic [N-1:0] Q,
    output logic         Z,
    output logic         done
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] q_q, q_d;
    logic [N-1:0] r_q, r_d;
    logic         done_q, done_d;
    logic         borrow;

    // Ripple borrow chain seeded by En: each stage passes the borrow only when
    // its bit below is zero, mirroring the up counter's carry chain.
    always_comb begin
        logic ad;
        ad = En;
        for (int i = 0; i < N; i++) begin
            ad = ad & ~q_q[i];
        end
        borrow = ad;
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path can infer a latch.
        q_d    = q_q;
        r_d    = r_q;
        done_d = 1'b0;
        if (load) begin
            q_d = C;
            r_d = C;
        end else if (borrow) begin
            q_d    = reload_en ? r_q : '1;
            done_d = 1'b1;
        end else if (En) begin
            q_d = q_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (rst) begin
            q_q    <= '0;
            r_q    <= '0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            r_q    <= r_d;
            done_q <= done_d;
        end
    end

    assign Q    = q_q;
    assign Z    = borrow;
    assign done = done_q;

endmodule

// File: tb/tb_down_counter_parallel_load.sv
// Self-checking bench for down_counter_parallel_load: reference model feeding a
// scoreboard queue, plan-directed sequences, random traffic and a two-stage cascade.
module tb_down_counter_parallel_load;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst, En, load, reload_en;
    logic [N-1:0] C;
    logic [N-1:0] Q;
    logic         Z, done;

    // cascade pair: low stage Z drives high stage En
    logic         c_rst, c_load, c_en, c_rel;
    logic [N-1:0] lo_q, hi_q;
    logic         lo_z, hi_z, lo_done, hi_done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [N-1:0] q;
        logic         done;
    } exp_t;

    exp_t exp_q[$];

    logic [N-1:0] m_q, m_r;
    logic         m_done;
    logic         m_valid = 1'b0;

    always #5 clk = ~clk;

    down_counter_parallel_load #(.N(N)) dut (
        .clk(clk), .rst(rst), .En(En), .load(load), .C(C),
        .reload_en(reload_en), .Q(Q), .Z(Z), .done(done)
    );

    down_counter_parallel_load #(.N(N)) u_lo (
        .clk(clk), .rst(c_rst), .En(c_en), .load(c_load), .C(4'h0),
        .reload_en(c_rel), .Q(lo_q), .Z(lo_z), .done(lo_done)
    );

    down_counter_parallel_load #(.N(N)) u_hi (
        .clk(clk), .rst(c_rst), .En(lo_z), .load(c_load), .C(4'h1),
        .reload_en(c_rel), .Q(hi_q), .Z(hi_z), .done(hi_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle, check Z before the edge, predict and check Q/done after it.
    task automatic step(input logic r, input logic ld, input logic e,
                        input logic [N-1:0] c, input logic rl);
        exp_t item;
        @(negedge clk);
        rst = r; load = ld; En = e; C = c; reload_en = rl;
        #1;
        if (m_valid) check("Z", {31'b0, Z}, {31'b0, e & (m_q == '0)});
        if (r) begin
            m_q = '0; m_r = '0; m_done = 1'b0; m_valid = 1'b1;
        end else if (ld) begin
            m_q = c; m_r = c; m_done = 1'b0;
        end else if (e && m_q == '0) begin
            m_q = rl ? m_r : {N{1'b1}}; m_done = 1'b1;
        end else if (e) begin
            m_q = m_q - 4'd1; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
        end
        if (m_valid) exp_q.push_back('{q: m_q, done: m_done});
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            item = exp_q.pop_front();
            check("Q", {28'b0, Q}, {28'b0, item.q});
            check("done", {31'b0, done}, {31'b0, item.done});
        end
    endtask

    task automatic cstep(input logic r, input logic ld, input logic e);
        @(negedge clk);
        c_rst = r; c_load = ld; c_en = e; c_rel = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seq_q[5];
        int seq_d[5];
        int rl_q[6];
        rst = 1'b0; load = 1'b0; En = 1'b0; C = '0; reload_en = 1'b0;
        c_rst = 1'b0; c_load = 1'b0; c_en = 1'b0; c_rel = 1'b0;

        // reset overrides load and En
        step(1'b1, 1'b1, 1'b1, 4'd9, 1'b0);
        check("rst_q", {28'b0, Q}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        @(negedge clk); rst = 1'b0; load = 1'b0; En = 1'b1; #1;
        check("rst_z", {31'b0, Z}, 32'd1);

        // load 3, count down with wrap
        seq_q = '{2, 1, 0, 15, 14};
        seq_d = '{0, 0, 0, 1, 0};
        step(1'b0, 1'b1, 1'b0, 4'd3, 1'b0);
        check("load_q", {28'b0, Q}, 32'd3);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
            check("seq_q", {28'b0, Q}, seq_q[i]);
            check("seq_done", {31'b0, done}, seq_d[i]);
        end

        // auto-reload from R=2
        rl_q = '{1, 0, 2, 1, 0, 2};
        step(1'b0, 1'b1, 1'b0, 4'd2, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 1'b1, 4'd0, 1'b1);
            check("reload_q", {28'b0, Q}, rl_q[i]);
            check("reload_done", {31'b0, done}, {31'b0, rl_q[i] == 2});
        end

        // reload with R=0: stays at 0, done every enabled cycle
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 4'd0, 1'b1);
            check("r0_done", {31'b0, done}, 32'd1);
        end

        // load beats En at terminal count
        step(1'b0, 1'b1, 1'b1, 4'd7, 1'b0);
        check("prio_q", {28'b0, Q}, 32'd7);
        check("prio_done", {31'b0, done}, 32'd0);

        // hold
        step(1'b0, 1'b1, 1'b0, 4'd5, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
            check("hold_q", {28'b0, Q}, 32'd5);
        end
        step(1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        check("hold_go", {28'b0, Q}, 32'd4);

        // random traffic against the model, including mid-count resets
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)));
        end

        // cascade: {hi,lo} loaded with 0x10
        cstep(1'b1, 1'b0, 1'b0);
        cstep(1'b0, 1'b1, 1'b0);
        @(negedge clk); c_load = 1'b0; c_en = 1'b1; #1;
        check("cas_z_10", {31'b0, hi_z}, 32'd0);
        @(posedge clk); #1;
        check("cas_0f", {24'b0, hi_q, lo_q}, 32'h0F);
        for (int i = 0; i < 16; i++) cstep(1'b0, 1'b0, 1'b1);
        check("cas_ff", {24'b0, hi_q, lo_q}, 32'hFF);
        cstep(1'b1, 1'b0, 1'b0);
        @(negedge clk); c_rst = 1'b0; c_en = 1'b1; #1;
        check("cas_z_00", {31'b0, hi_z}, 32'd1);
        c_en = 1'b0; #1;
        check("cas_z_noen", {31'b0, hi_z}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/down_counter_parallel_load.md
Name: down_counter_parallel_load

Overview:
- N-bit synchronous down counter with parallel load, count enable and cascadable borrow-out.
- Counterpart of the team's up counter with parallel load, covering the opposite counting direction.
- Used for countdown timers and delay generators.
- Adds a reload register with auto-reload, and a registered terminal-count pulse for downstream sequential logic.

Parameters:
- N, 4, counter width in bits (N >= 2).

Ports:
- clk  input  1  rising-edge clock; the single clock domain.
- rst  input  1  synchronous, active-high reset.
- En  input  1  count enable; decrement by 1 per enabled edge.
- load  input  1  parallel load strobe; higher priority than En.
- C  input  N  parallel load value.
- reload_en  input  1  1 = auto-reload from reload register at terminal count; 0 = free-run wrap.
- Q  output  N  current count.
- Z  output  1  combinational borrow-out: En & (Q == 0); used to cascade the next stage's En.
- done  output  1  registered one-cycle pulse, asserted the cycle after an enabled count from Q == 0.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. All state updates occur on the rising edge of clk only.
- Reset (rst=1 at edge):
  - Q <= 0, reload register R <= 0, done <= 0.
  - Z follows its equation, so Z = En after reset.
  - rst overrides load and En in the same cycle.
- Priority per edge: rst > load > En > hold.
- load=1:
  - Q <= C and R <= C; done <= 0.
  - En is ignored that cycle, even if Q == 0.
- load=0, En=1, Q != 0: Q <= Q - 1; done <= 0.
- load=0, En=1, Q == 0 (terminal count):
  - reload_en=1: Q <= R.
  - reload_en=0: Q <= all ones (2^N - 1), i.e. modulo-2^N wrap.
  - Either case: done <= 1 for exactly one cycle.
- load=0, En=0: Q, R hold; done <= 0.
- Z is purely combinational, with no register latency. It is asserted in the same cycle as the terminal-count edge condition, one cycle before done.
- Borrow chain: Z equals the AND of En with all inverted Q bits. This is built with the same ripple structure as the up counter's carry chain (ad[i] = ~Q[i-1] & ad[i-1], seeded by En), so stages cascade by wiring Z to the next stage's En.
- Count sequence example (N=4, reload_en=0): 3,2,1,0,15,14,...
- Reload with R == 0 and reload_en=1: Q stays 0; done pulses on every enabled cycle.
- reload_en is sampled only at the terminal-count edge and may change at any time.
- Arithmetic is modulo 2^N; no overflow or underflow flags beyond Z and done.
- Reset mid-count: the next edge forces the reset values, and the counting history is discarded.

Test Plan:
- Reset: N=4, drive rst=1 with load=1, C=9, En=1 for one edge -> Q=0, done=0. With En=1 after reset, Z=1.
- Load and count down: load C=3 then En=1 for 5 edges, reload_en=0 -> Q: 3,2,1,0,15,14.
  - Z=1 only while Q=0.
  - done=1 only in the cycle where Q=15.
- Auto-reload: load C=2, reload_en=1, En=1 continuously -> Q: 2,1,0,2,1,0,2.
  - done pulses one cycle after each 0→2 transition edge, period 3.
- Load vs enable priority: Q=0, En=1, load=1, C=7 at the same edge -> Q=7, done=0.
  - The terminal count is not taken.
- Hold: Q=5, En=0 for 4 edges -> Q stays 5, Z=0, done=0.
  - Then En=1 -> Q=4.
- Cascade: two N=4 instances, low.Z driving high.En, both loaded with 0x10 (high=1, low=0), En=1.
  - 1st edge: 0x0F.
  - 16 more edges: 0xFF (wrap).
  - Combined Z of the high instance is 1 only when both Q=0 and En=1.
